// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory bus port between
// instruction fetch (IF) and the MEM stage. One bus transaction in flight:
// IDLE (arbitrate + latch) -> ADDR (valid/ready handshake) -> RESP (wait for
// response) -> IDLE (owner's done pulse).
// Build option: define YSYX_22040931_ARB_RR_EN for round-robin arbitration;
// without it MEM has fixed priority over IF.

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    // instruction fetch side
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [DATA_W-1:0]     if_rdata,
    // MEM stage side
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wmask,
    output logic                  mem_done,
    output logic [DATA_W-1:0]     mem_rdata,
    // memory bus
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_wr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wmask,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_W-1:0]     bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_mem_q, owner_mem_d;   // 1 = MEM owns the bus, 0 = IF
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic                  drop_q, drop_d;             // in-flight fetch result is stale
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

    logic                  if_elig;
    logic                  mem_elig;
    logic                  grant_mem;

`ifdef YSYX_22040931_ARB_RR_EN
    logic                  rr_mem_q, rr_mem_d;         // 1 = MEM wins the next tie
`endif

    // Eligibility and winner selection; a requester still seeing its done
    // pulse holds a stale request and must not be granted again.
    always_comb begin
        mem_elig = mem_req & ~mem_done_q;
        if_elig  = if_req & ~if_flush & ~if_done_q;
`ifdef YSYX_22040931_ARB_RR_EN
        grant_mem = mem_elig & (~if_elig | rr_mem_q);
`else
        grant_mem = mem_elig;
`endif
    end

    // Next-state and datapath: latch in IDLE, handshake in ADDR, capture in RESP.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        drop_d      = drop_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef YSYX_22040931_ARB_RR_EN
        rr_mem_d    = rr_mem_q;
`endif

        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (mem_elig || if_elig) begin
                    state_d     = S_ADDR;
                    owner_mem_d = grant_mem;
`ifdef YSYX_22040931_ARB_RR_EN
                    rr_mem_d    = ~grant_mem;
`endif
                    if (grant_mem) begin
                        wr_d    = mem_wr;
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        wmask_d = mem_wr ? mem_wmask : '0;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            S_ADDR: begin
                if (!owner_mem_q && if_flush) drop_d = 1'b1;
                if (bus_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (!owner_mem_q && if_flush) drop_d = 1'b1;
                if (bus_rsp_valid) begin
                    state_d = S_IDLE;
                    if (owner_mem_q) begin
                        mem_done_d = 1'b1;
                        if (!wr_q) mem_rdata_d = bus_rdata;
                    end else if (!(drop_q || if_flush)) begin
                        // A redirect in the capture cycle also discards the fetch.
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            drop_q      <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef YSYX_22040931_ARB_RR_EN
            rr_mem_q    <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            drop_q      <= drop_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef YSYX_22040931_ARB_RR_EN
            rr_mem_q    <= rr_mem_d;
`endif
        end
    end

    assign bus_valid = (state_q == S_ADDR);
    assign bus_wr    = wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wmask = wmask_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a transaction-level model.
// Honours YSYX_22040931_ARB_RR_EN the same way the design does.

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req, if_flush, if_done;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req, mem_wr, mem_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [STRB_W-1:0] mem_wmask;
    logic              bus_valid, bus_ready, bus_wr, bus_rsp_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;
    logic [STRB_W-1:0] bus_wmask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic              m_active, m_accepted, m_dropped, m_owner_mem, m_pref_mem;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_if_rdata, m_mem_rdata;
    logic [STRB_W-1:0] m_wmask;
    logic              m_if_done, m_mem_done;
    logic              e_mem, e_if, g_mem, nx_if_done, nx_mem_done, exp_valid;
    logic              if_busy, mem_busy;

    // Watchdog: the bench is time-bounded even if something hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = '0; if_flush = 0;
        mem_req = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        bus_ready = 0; bus_rsp_valid = 0; bus_rdata = '0;

        // ---- reset state ----
        tick(); tick();
        check("rst_bus_valid", bus_valid, 0);
        check("rst_bus_wr", bus_wr, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wmask", bus_wmask, 0);
        check("rst_if_done", if_done, 0);
        check("rst_mem_done", mem_done, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        reset = 1'b0;
        tick();

        // ---- lone fetch, minimum latency ----
        if_req = 1; if_addr = 32'h8000_0000; bus_ready = 1;
        tick();
        check("t1_bus_valid", bus_valid, 1);
        check("t1_bus_addr", bus_addr, 32'h8000_0000);
        check("t1_bus_wr", bus_wr, 0);
        check("t1_bus_wmask", bus_wmask, 0);
        if_addr = 32'h1234_5678;                    // ignored once latched
        tick();
        check("t1_resp_valid", bus_valid, 0);
        check("t1_resp_done", if_done, 0);
        check("t1_resp_addr", bus_addr, 32'h8000_0000);
        bus_rsp_valid = 1; bus_rdata = 64'h13;
        tick();
        check("t1_if_done", if_done, 1);
        check("t1_if_rdata", if_rdata, 64'h13);
        bus_rsp_valid = 0; if_req = 0;
        tick();
        check("t1_done_pulse", if_done, 0);
        check("t1_rdata_hold", if_rdata, 64'h13);

        // ---- simultaneous requests: MEM store first ----
        if_req = 1; if_addr = 32'h8000_0000;
        mem_req = 1; mem_wr = 1; mem_addr = 32'h8000_1000;
        mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
        tick();
        check("t2_bus_valid", bus_valid, 1);
        check("t2_bus_addr", bus_addr, 32'h8000_1000);
        check("t2_bus_wr", bus_wr, 1);
        check("t2_bus_wmask", bus_wmask, 8'h0F);
        check("t2_bus_wdata", bus_wdata, 64'hDEAD_BEEF);
        tick();
        bus_rsp_valid = 1; bus_rdata = 64'hFFFF_FFFF;
        tick();
        check("t2_mem_done", mem_done, 1);
        check("t2_mem_rdata_unchanged", mem_rdata, 0);
        check("t2_done_cycle_idle", bus_valid, 0);
        bus_rsp_valid = 0; bus_ready = 0;           // mem_req still held: masked
        tick();
        check("t2_if_valid", bus_valid, 1);
        check("t2_if_addr", bus_addr, 32'h8000_0000);
        check("t2_if_wr", bus_wr, 0);
        check("t2_mem_done_pulse", mem_done, 0);
        mem_req = 0;

        // ---- bus stalls five cycles in ADDR ----
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", bus_valid, 1);
            check("t3_stall_addr", bus_addr, 32'h8000_0000);
            check("t3_stall_wdata", bus_wdata, 0);
            check("t3_stall_if_done", if_done, 0);
            check("t3_stall_mem_done", mem_done, 0);
            tick();
        end
        check("t3_sixth_valid", bus_valid, 1);
        bus_ready = 1;
        tick();
        check("t3_accepted", bus_valid, 0);

        // ---- fetch flushed in RESP, pending load takes over ----
        if_flush = 1; if_req = 0;
        mem_req = 1; mem_wr = 0; mem_addr = 32'h0000_0100;
        tick();
        if_flush = 0;
        bus_rsp_valid = 1; bus_rdata = 64'hAAAA;
        tick();
        check("t4_no_if_done", if_done, 0);
        check("t4_if_rdata_kept", if_rdata, 64'h13);
        bus_rsp_valid = 0; bus_ready = 0;
        tick();
        check("t4_mem_valid", bus_valid, 1);
        check("t4_mem_addr", bus_addr, 32'h0000_0100);
        check("t4_mem_read_wr", bus_wr, 0);
        check("t4_mem_read_mask", bus_wmask, 0);
        check("t4_still_no_if_done", if_done, 0);

        // ---- reset in ADDR, then a fresh fetch ----
        reset = 1; mem_req = 0;
        tick();
        check("t6_valid", bus_valid, 0);
        check("t6_wr", bus_wr, 0);
        check("t6_addr", bus_addr, 0);
        check("t6_if_done", if_done, 0);
        check("t6_mem_done", mem_done, 0);
        check("t6_if_rdata", if_rdata, 0);
        check("t6_mem_rdata", mem_rdata, 0);
        reset = 0;
        tick();
        if_req = 1; if_addr = 32'h8000_0040; bus_ready = 1;
        tick();
        check("t6_fetch_valid", bus_valid, 1);
        check("t6_fetch_addr", bus_addr, 32'h8000_0040);
        tick();
        bus_rsp_valid = 1; bus_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        check("t6_fetch_done", if_done, 1);
        check("t6_fetch_rdata", if_rdata, 64'h0123_4567_89AB_CDEF);
        bus_rsp_valid = 0; if_req = 0;

        // ---- randomized run against the model ----
        reset = 1;
        tick(); tick();
        reset = 0;
        m_active = 0; m_accepted = 0; m_dropped = 0; m_owner_mem = 0; m_pref_mem = 1;
        m_wr = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_if_rdata = '0; m_mem_rdata = '0; m_if_done = 0; m_mem_done = 0;
        if_busy = 0; mem_busy = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            // compare DUT against the model's view of this cycle
            exp_valid = m_active && !m_accepted;
            check("rnd_bus_valid", bus_valid, exp_valid);
            check("rnd_if_done", if_done, m_if_done);
            check("rnd_mem_done", mem_done, m_mem_done);
            check("rnd_if_rdata", if_rdata, m_if_rdata);
            check("rnd_mem_rdata", mem_rdata, m_mem_rdata);
            if (exp_valid) begin
                check("rnd_bus_addr", bus_addr, m_addr);
                check("rnd_bus_wr", bus_wr, m_wr);
                check("rnd_bus_wmask", bus_wmask, m_wmask);
                if (m_wr) check("rnd_bus_wdata", bus_wdata, m_wdata);
            end

            // IF requester: holds until done or flush; request stays up in the done cycle
            if_flush = 0;
            if (m_if_done) begin
                if_busy = 0;
            end else if (if_busy) begin
                if ($urandom_range(11) == 0) begin
                    if_flush = 1;
                    if_busy  = 0;
                end
            end else if ($urandom_range(1) == 1) begin
                if_req = 1; if_addr = $urandom; if_busy = 1;
            end else begin
                if_req = 0; if_addr = $urandom;
                if ($urandom_range(15) == 0) if_flush = 1;
            end

            // MEM requester: holds until done; scrambles inputs once its access is latched
            if (m_mem_done) begin
                mem_busy = 0;
            end else if (mem_busy) begin
                if (m_active && m_owner_mem) begin
                    mem_wr = 1'($urandom); mem_addr = $urandom;
                    mem_wdata = {$urandom, $urandom}; mem_wmask = 8'($urandom);
                end
            end else begin
                mem_wr = 1'($urandom); mem_addr = $urandom;
                mem_wdata = {$urandom, $urandom}; mem_wmask = 8'($urandom);
                mem_req = ($urandom_range(1) == 1);
                mem_busy = mem_req;
            end

            // bus responder; responses outside RESP must be ignored
            bus_ready     = ($urandom_range(2) != 0);
            bus_rsp_valid = ($urandom_range(2) == 0);
            bus_rdata     = {$urandom, $urandom};

            // model: what the arbiter must look like after the coming edge
            nx_if_done = 0; nx_mem_done = 0;
            if (!m_active) begin
                e_mem = mem_req && !m_mem_done;
                e_if  = if_req && !if_flush && !m_if_done;
                if (e_mem || e_if) begin
`ifdef YSYX_22040931_ARB_RR_EN
                    g_mem = e_mem && (!e_if || m_pref_mem);
                    m_pref_mem = !g_mem;
`else
                    g_mem = e_mem;
`endif
                    m_active = 1; m_accepted = 0; m_dropped = 0; m_owner_mem = g_mem;
                    m_addr  = g_mem ? mem_addr : if_addr;
                    m_wr    = g_mem && mem_wr;
                    m_wdata = g_mem ? mem_wdata : '0;
                    m_wmask = (g_mem && mem_wr) ? mem_wmask : '0;
                end
            end else begin
                if (!m_owner_mem && if_flush) m_dropped = 1;
                if (!m_accepted) begin
                    if (bus_ready) m_accepted = 1;
                end else if (bus_rsp_valid) begin
                    m_active = 0;
                    if (m_owner_mem) begin
                        nx_mem_done = 1;
                        if (!m_wr) m_mem_rdata = bus_rdata;
                    end else if (!m_dropped) begin
                        nx_if_done = 1;
                        m_if_rdata = bus_rdata;
                    end
                end
            end
            m_if_done  = nx_if_done;
            m_mem_done = nx_mem_done;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
